mod16_counter: RTL and testbench
================================

Name: mod16_counter

Overview:
- 4-bit (mod-16) synchronous up/down counter with synchronous parallel preload.
- Used as a general-purpose sequence/event counter.
- Counts once per rising clock edge in the direction selected by `x`.
- Wraps modulo 2^WIDTH, with no saturation.

Parameters:
- WIDTH, 4, counter width in bits; modulus is 2^WIDTH (16 at default).

Ports:
- clk  input  1  system clock; all non-reset state changes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces count to 0 immediately.
- x  input  1  direction select; 1 = count up, 0 = count down.
- preload  input  1  synchronous load enable, active-high.
- load  input  WIDTH  value loaded into count when preload = 1.
- count  output  WIDTH  current counter value, registered.
- Port declaration order is fixed as x, clk, reset, preload, load, count so that positional instantiation connects correctly.

Behaviour:
- Single clock domain; one register of WIDTH bits drives count directly, with no combinational path from inputs to count.
- Reset:
  - reset = 0 clears count to 0 asynchronously, without waiting for a clock edge.
  - count stays 0 while reset is low, regardless of x, preload, load or clk.
  - Deassertion (0->1) takes effect at the next rising clk edge. The first edge with reset = 1 performs a normal update from 0.
- Priority at each rising clk edge with reset = 1:
  1. preload = 1: count <= load, with one-cycle latency. x is ignored.
  2. preload = 0, x = 1: count <= count + 1 mod 2^WIDTH.
  3. preload = 0, x = 0: count <= count - 1 mod 2^WIDTH.
- Counter always runs; there is no separate hold/enable input. Holding a value requires preload = 1 with load = count.
- Wrap-around:
  - Up from 15 goes to 0.
  - Down from 0 goes to 15.
  - No carry or borrow output.
- Inputs x, preload and load are sampled only at rising clk edges. Changes between edges have no effect until the next edge.
- Reset mid-operation: count drops to 0 at the moment reset falls, even between clock edges. Any preload in progress is discarded.
- Unknown inputs: after reset release, preload and x are driven to known values by the environment. The block performs no X-handling.

Test Plan:
- Async reset: hold reset = 0 with clk toggling and x = 1 -> count = 0 throughout. Pulse reset low between clk edges while count = 9 -> count = 0 before the next edge.
- Up count and wrap: reset released, preload = 0, x = 1 for 20 edges -> count 1, 2, …, 15, 0, 1, 2, 3, 4.
- Down count and wrap: from count = 2, x = 0 for 4 edges -> 1, 0, 15, 14.
- Preload priority: preload = 1, load = 4'b1010, x = 1 -> count = 10 after one edge and stays 10 while preload is held. Release preload with x = 1 -> 11.
- Preload versus direction: preload = 1, load = 0, x = 0 -> count = 0 (no decrement). Next edge with preload = 0 -> 15.
- Direction change mid-run: x = 1 until count = 7, then x = 0 -> 6, 5 on the following edges, with no skipped or duplicated values.

Source files
------------

// File: rtl/mod16_counter.sv
// mod16_counter: WIDTH-bit up/down wrap-around counter with synchronous parallel preload.
// Latency: one clk edge from sampled x/preload/load to count; reset clears count immediately.
// Backpressure: none; the counter advances on every rising edge unless preloaded.
//
// Ports:
//   x       - direction select, 1 = up, 0 = down (ignored while preload = 1)
//   clk     - rising-edge clock
//   reset   - asynchronous active-low clear
//   preload - synchronous load enable, takes priority over counting
//   load    - value captured into count when preload = 1
//   count   - registered counter value
module mod16_counter #(
   parameter int WIDTH = 4
) (
   input  logic             x,
   input  logic             clk,
   input  logic             reset,
   input  logic             preload,
   input  logic [WIDTH-1:0] load,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] one = WIDTH'(1);

   // Arithmetic is kept at WIDTH bits so up from all-ones and down from zero
   // wrap naturally modulo 2^WIDTH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (preload) begin
         count <= load;
      end else if (x) begin
         count <= count + one;
      end else begin
         count <= count - one;
      end
   end

endmodule

// File: tb/tb_mod16_counter.sv
module tb_mod16_counter;

   logic       clk;
   logic       reset;
   logic       x;
   logic       preload;
   logic [3:0] load;
   logic [3:0] count;

   int errors = 0;
   int checks = 0;

   logic [3:0] exp_q[$];
   string      nm_q[$];
   event       chk_ev;

   mod16_counter #(.WIDTH(4)) dut (
      .x       (x),
      .clk     (clk),
      .reset   (reset),
      .preload (preload),
      .load    (load),
      .count   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compares every queued expectation against count, on each falling
   // edge or immediately when the driver signals an off-edge check.
   initial begin
      logic [3:0] e;
      string      n;
      forever begin
         @(negedge clk or chk_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (count !== e) begin
               errors++;
               $display("FAIL %s: count=%0d expected %0d at t=%0t", n, count, e, $time);
            end
         end
      end
   end

   task automatic push(input logic [3:0] e, input string n);
      exp_q.push_back(e);
      nm_q.push_back(n);
   endtask

   // Apply inputs for one edge, then queue the value count must hold after it.
   task automatic step(input logic xi, input logic pi, input logic [3:0] li,
                       input logic [3:0] e, input string n);
      x       = xi;
      preload = pi;
      load    = li;
      @(posedge clk);
      #1;
      push(e, n);
   endtask

   initial begin
      reset   = 1'b0;
      x       = 1'b1;
      preload = 1'b0;
      load    = 4'd0;

      // Reset state, then held low across several edges with x = 1.
      #1;
      push(4'd0, "reset_init");
      ->chk_ev;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         push(4'd0, $sformatf("reset_hold%0d", i));
      end
      reset = 1'b1;

      // Up count with wrap: 1..15, 0, 1..4.
      for (int i = 1; i <= 20; i++) begin
         step(1'b1, 1'b0, 4'd0, 4'(i), $sformatf("up%0d", i));
      end

      // Preload 9, then pulse reset low in the low phase between edges.
      step(1'b1, 1'b1, 4'd9, 4'd9, "pre9");
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      push(4'd0, "async_rst_mid");
      ->chk_ev;
      #1;
      reset = 1'b1;

      // First edge after release counts normally from 0.
      step(1'b1, 1'b0, 4'd0, 4'd1, "post_rst1");
      step(1'b1, 1'b0, 4'd0, 4'd2, "post_rst2");

      // Down count with wrap: 2 -> 1, 0, 15, 14.
      step(1'b0, 1'b0, 4'd0, 4'd1,  "dn1");
      step(1'b0, 1'b0, 4'd0, 4'd0,  "dn0");
      step(1'b0, 1'b0, 4'd0, 4'd15, "dn15");
      step(1'b0, 1'b0, 4'd0, 4'd14, "dn14");

      // Preload beats up-count and holds while asserted.
      step(1'b1, 1'b1, 4'b1010, 4'd10, "pre10_a");
      step(1'b1, 1'b1, 4'b1010, 4'd10, "pre10_b");
      step(1'b1, 1'b1, 4'b1010, 4'd10, "pre10_c");
      step(1'b1, 1'b0, 4'b1010, 4'd11, "rel_up11");

      // Preload beats down-count; next edge decrements through zero.
      step(1'b0, 1'b1, 4'd0, 4'd0,  "pre0_dn");
      step(1'b0, 1'b0, 4'd0, 4'd15, "dn_wrap15");

      // Direction change mid-run: up to 7, then down.
      step(1'b1, 1'b1, 4'd5, 4'd5, "pre5");
      step(1'b1, 1'b0, 4'd0, 4'd6, "dir_up6");
      step(1'b1, 1'b0, 4'd0, 4'd7, "dir_up7");
      step(1'b0, 1'b0, 4'd0, 4'd6, "dir_dn6");
      step(1'b0, 1'b0, 4'd0, 4'd5, "dir_dn5");

      // Input changes between edges must not affect count.
      x = 1'b1;
      preload = 1'b0;
      @(negedge clk);
      #1;
      preload = 1'b1;
      load    = 4'd12;
      #2;
      preload = 1'b0;
      @(posedge clk);
      #1;
      push(4'd6, "midcycle_glitch");

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: time=%0t expected completion", $time);
      $fatal(1, "timeout");
   end

endmodule
